// File: rtl/lpif_ustrm_pkg.sv
// Shared types for the LPIF upstream transmit shaper.
// Shaper FSM states, flit entry layout and LPIF state codes.
package lpif_ustrm_pkg;

  localparam int USTRM_DATA_W = 32;

  typedef enum logic [1:0] {
    OFFLINE,
    RUN,
    DRAIN,
    APPLY
  } shaper_st_t;

  typedef struct packed {
    logic [1:0]              protid;
    logic                    crc;
    logic                    crc_valid;
    logic [USTRM_DATA_W-1:0] data;
  } ustrm_entry_t;

  localparam logic [3:0] LPIF_RESET     = 4'h0;
  localparam logic [3:0] LPIF_ACTIVE    = 4'h1;
  localparam logic [3:0] LPIF_L1        = 4'h4;
  localparam logic [3:0] LPIF_L2        = 4'h8;
  localparam logic [3:0] LPIF_LINKRESET = 4'h9;
  localparam logic [3:0] LPIF_RETRAIN   = 4'hB;
  localparam logic [3:0] LPIF_DISABLED  = 4'hC;

endpackage

// File: rtl/lpif_ustrm_sfifo.sv
// Synchronous FIFO for shaper flits.
// The head is read straight from storage, so it is visible the cycle after its write.
module lpif_ustrm_sfifo #(
  parameter int DEPTH = 8,
  parameter int W     = 36
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/lpif_ustrm_tx_shaper.sv
// Upstream feeder for the LPIF slave link: buffers adapter flits
// and orders LPIF state changes behind queued data.
module lpif_ustrm_tx_shaper
  import lpif_ustrm_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                   clk_wr,
  input  logic                   rst_wr_n,
  input  logic                   tx_online,
  input  logic                   usr_valid,
  output logic                   usr_ready,
  input  logic [DATA_W-1:0]      usr_data,
  input  logic [1:0]             usr_protid,
  input  logic                   usr_crc,
  input  logic                   usr_crc_valid,
  input  logic                   state_req,
  input  logic [3:0]             state_val,
  output logic                   state_ack,
  output logic [3:0]             ustrm_state,
  output logic [1:0]             ustrm_protid,
  output logic [DATA_W-1:0]      ustrm_data,
  output logic                   ustrm_dvalid,
  output logic                   ustrm_crc,
  output logic                   ustrm_crc_valid,
  output logic                   ustrm_valid,
  output logic [$clog2(DEPTH):0] fifo_level
);

  typedef struct packed {
    logic [1:0]        protid;
    logic              crc;
    logic              crc_valid;
    logic [DATA_W-1:0] data;
  } entry_t;

  shaper_st_t st;
  shaper_st_t st_nx;
  entry_t     wr_e;
  entry_t     rd_e;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       apply;

  assign usr_ready = !full && (st != DRAIN) && (st != APPLY);
  assign push      = usr_valid && usr_ready;
  assign pop       = ((st == RUN) || (st == DRAIN)) && tx_online && !empty;
  assign wr_e      = '{usr_protid, usr_crc, usr_crc_valid, usr_data};

  lpif_ustrm_sfifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk   (clk_wr),
    .rst_n (rst_wr_n),
    .push  (push),
    .pop   (pop),
    .wdata (wr_e),
    .rdata (rd_e),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_comb begin
    st_nx = st;
    unique case (st)
      OFFLINE: if (tx_online) st_nx = RUN;
      RUN: begin
        if (!tx_online)     st_nx = OFFLINE;
        else if (state_req) st_nx = DRAIN;
      end
      DRAIN: begin
        if (!tx_online)          st_nx = OFFLINE;
        else if (empty && !pop)  st_nx = APPLY;
      end
      APPLY: st_nx = RUN;
    endcase
  end

  // State and ack are registered on entry so both show during APPLY.
  assign apply = (st == DRAIN) && (st_nx == APPLY);

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      st              <= OFFLINE;
      state_ack       <= 1'b0;
      ustrm_state     <= LPIF_RESET;
      ustrm_protid    <= '0;
      ustrm_data      <= '0;
      ustrm_dvalid    <= 1'b0;
      ustrm_crc       <= 1'b0;
      ustrm_crc_valid <= 1'b0;
      ustrm_valid     <= 1'b0;
    end else begin
      st              <= st_nx;
      state_ack       <= apply;
      ustrm_valid     <= tx_online && (st != OFFLINE);
      ustrm_dvalid    <= pop;
      ustrm_data      <= pop ? rd_e.data : '0;
      ustrm_crc       <= pop && rd_e.crc;
      ustrm_crc_valid <= pop && rd_e.crc_valid;
      if (pop)   ustrm_protid <= rd_e.protid;
      if (apply) ustrm_state  <= state_val;
    end
  end

endmodule

// File: tb/tb_lpif_ustrm_tx_shaper.sv
// Scoreboard bench for the LPIF upstream transmit shaper.
// Accepted flits are queued; a monitor checks every emitted flit.
module tb_lpif_ustrm_tx_shaper;
  import lpif_ustrm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_online = 1'b0;
  logic        usr_valid = 1'b0;
  logic        usr_ready;
  logic [31:0] usr_data = '0;
  logic [1:0]  usr_protid = '0;
  logic        usr_crc = 1'b0;
  logic        usr_crc_valid = 1'b0;
  logic        state_req = 1'b0;
  logic [3:0]  state_val = '0;
  logic        state_ack;
  logic [3:0]  ustrm_state;
  logic [1:0]  ustrm_protid;
  logic [31:0] ustrm_data;
  logic        ustrm_dvalid;
  logic        ustrm_crc;
  logic        ustrm_crc_valid;
  logic        ustrm_valid;
  logic [3:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int ack_cnt = 0;
  logic mon_en = 1'b0;
  ustrm_entry_t exp_q[$];
  ustrm_entry_t mon_e;

  always #5 clk = ~clk;

  lpif_ustrm_tx_shaper #(.DEPTH(8), .DATA_W(32)) dut (
    .clk_wr          (clk),
    .rst_wr_n        (rst_n),
    .tx_online       (tx_online),
    .usr_valid       (usr_valid),
    .usr_ready       (usr_ready),
    .usr_data        (usr_data),
    .usr_protid      (usr_protid),
    .usr_crc         (usr_crc),
    .usr_crc_valid   (usr_crc_valid),
    .state_req       (state_req),
    .state_val       (state_val),
    .state_ack       (state_ack),
    .ustrm_state     (ustrm_state),
    .ustrm_protid    (ustrm_protid),
    .ustrm_data      (ustrm_data),
    .ustrm_dvalid    (ustrm_dvalid),
    .ustrm_crc       (ustrm_crc),
    .ustrm_crc_valid (ustrm_crc_valid),
    .ustrm_valid     (ustrm_valid),
    .fifo_level      (fifo_level)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    usr_valid = 1'b0;
    state_req = 1'b0;
    tick();
    tick();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] p,
                       input logic c, input logic cv);
    usr_valid = 1'b1;
    usr_data = d;
    usr_protid = p;
    usr_crc = c;
    usr_crc_valid = cv;
  endtask

  // Record each accepted flit as the expected output.
  always @(negedge clk) begin
    if (rst_n && usr_valid && usr_ready)
      exp_q.push_back(ustrm_entry_t'{usr_protid, usr_crc,
                                     usr_crc_valid, usr_data});
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (state_ack) ack_cnt++;
      if (ustrm_dvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected got %0h want none", ustrm_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_flit", {ustrm_protid, ustrm_crc, ustrm_crc_valid,
                          ustrm_data}, 64'(mon_e));
          rx_cnt++;
        end
      end else begin
        chk("idle_zero", {ustrm_crc, ustrm_crc_valid, ustrm_data}, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int nfl;
    int rx0;
    int ack0;
    logic ok;
    logic got;
    logic acc;

    // Test 1: back-to-back latency
    tx_online = 1'b1;
    do_reset();
    smp();
    chk("rst_state", ustrm_state, 0);
    chk("rst_data", ustrm_data, 0);
    chk("rst_dvalid", ustrm_dvalid, 0);
    chk("rst_valid", ustrm_valid, 0);
    chk("rst_protid", ustrm_protid, 0);
    chk("rst_crc", {ustrm_crc, ustrm_crc_valid}, 0);
    chk("rst_ack", state_ack, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", usr_ready, 1);
    mon_en = 1'b1;
    tick();
    drive(32'hA0, 2'd1, 1'b1, 1'b1);
    tick();
    drive(32'hA1, 2'd2, 1'b0, 1'b1);
    tick();
    drive(32'hA2, 2'd3, 1'b1, 1'b0);
    smp();
    chk("t1_dv_c3", ustrm_dvalid, 1);
    chk("t1_data_c3", ustrm_data, 32'hA0);
    tick();
    usr_valid = 1'b0;
    smp();
    chk("t1_data_c4", ustrm_data, 32'hA1);
    tick();
    smp();
    chk("t1_data_c5", ustrm_data, 32'hA2);
    chk("t1_protid_c5", ustrm_protid, 3);
    chk("t1_uvalid", ustrm_valid, 1);
    tick();
    smp();
    chk("t1_level", fifo_level, 0);
    chk("t1_idle_protid", ustrm_protid, 3);
    tick();

    // Test 2: fill while offline, then drain
    tx_online = 1'b0;
    do_reset();
    rx0 = rx_cnt;
    for (int i = 0; i < 8; i++) begin
      drive(32'hB0 + 32'(i), 2'(i), i[0], ~i[0]);
      smp();
      chk("t2_ready", usr_ready, 1);
      tick();
    end
    drive(32'hB8, 2'd0, 1'b1, 1'b1);
    smp();
    chk("t2_full_ready", usr_ready, 0);
    chk("t2_full_level", fifo_level, 8);
    chk("t2_off_dvalid", ustrm_dvalid, 0);
    chk("t2_off_uvalid", ustrm_valid, 0);
    tick();
    tick();
    smp();
    chk("t2_hold_level", fifo_level, 8);
    tick();
    tx_online = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      smp();
      ok = usr_ready;
      tick();
    end
    usr_valid = 1'b0;
    chk("t2_b8_accept", ok, 1);
    for (int n = 0; n < 40; n++) begin
      if (fifo_level == 0 && exp_q.size() == 0) break;
      tick();
    end
    tick();
    chk("t2_q_empty", exp_q.size(), 0);
    chk("t2_rx_count", rx_cnt - rx0, 9);

    // Test 3: state change ordered behind 4 flits
    tx_online = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(32'hC0 + 32'(i), 2'(3 - i), i[1], 1'b1);
      tick();
    end
    usr_valid = 1'b0;
    smp();
    chk("t3_level", fifo_level, 4);
    tick();
    tx_online = 1'b1;
    state_req = 1'b1;
    state_val = LPIF_ACTIVE;
    tick();
    tick();
    smp();
    chk("t3_drain_ready", usr_ready, 0);
    chk("t3_state_old", ustrm_state, 0);
    nfl = int'(ustrm_dvalid);
    got = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      smp();
      if (state_ack) begin
        got = 1'b1;
        break;
      end
      nfl += int'(ustrm_dvalid);
    end
    chk("t3_ack", got, 1);
    chk("t3_state_new", ustrm_state, LPIF_ACTIVE);
    chk("t3_flits_before", nfl, 4);
    chk("t3_ack_dvalid", ustrm_dvalid, 0);
    tick();
    state_req = 1'b0;
    ack0 = ack_cnt;
    smp();
    chk("t3_ack_pulse", state_ack, 0);
    tick();
    tick();
    tick();
    chk("t3_ack_once", ack_cnt, ack0);

    // DRAIN with an empty FIFO: ack two cycles after request
    state_req = 1'b1;
    state_val = LPIF_L1;
    smp();
    chk("te_ack_r0", state_ack, 0);
    tick();
    smp();
    chk("te_ack_r1", state_ack, 0);
    chk("te_ready_r1", usr_ready, 0);
    tick();
    smp();
    chk("te_ack_r2", state_ack, 1);
    chk("te_state_r2", ustrm_state, LPIF_L1);
    tick();
    state_req = 1'b0;

    // Test 4: link drops during DRAIN with 2 flits queued
    tx_online = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(32'hD0 + 32'(i), 2'(i), 1'b0, i[0]);
      tick();
    end
    usr_valid = 1'b0;
    tx_online = 1'b1;
    state_req = 1'b1;
    state_val = LPIF_L2;
    tick();
    tick();
    tx_online = 1'b0;
    ack0 = ack_cnt;
    smp();
    chk("t4_drain_ready", usr_ready, 0);
    chk("t4_level", fifo_level, 2);
    for (int n = 0; n < 5; n++) begin
      tick();
      smp();
      chk("t4_off_dvalid", ustrm_dvalid, 0);
      chk("t4_off_ack", state_ack, 0);
      chk("t4_off_level", fifo_level, 2);
    end
    chk("t4_state_held", ustrm_state, LPIF_L1);
    tick();
    chk("t4_no_ack", ack_cnt, ack0);
    tx_online = 1'b1;
    nfl = 0;
    got = 1'b0;
    for (int n = 0; n < 30; n++) begin
      smp();
      if (state_ack) begin
        got = 1'b1;
        break;
      end
      nfl += int'(ustrm_dvalid);
      tick();
    end
    chk("t4_ack", got, 1);
    chk("t4_state", ustrm_state, LPIF_L2);
    chk("t4_flits_before", nfl, 2);
    tick();
    state_req = 1'b0;

    // Test 5: reset in the middle of a burst
    for (int i = 0; i < 3; i++) begin
      drive(32'hE0 + 32'(i), 2'(i), 1'b1, 1'b1);
      tick();
    end
    drive(32'hE3, 2'd3, 1'b1, 1'b1);
    rst_n = 1'b0;
    tick();
    usr_valid = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
    smp();
    chk("t5_dvalid", ustrm_dvalid, 0);
    chk("t5_data", ustrm_data, 0);
    chk("t5_uvalid", ustrm_valid, 0);
    chk("t5_protid", ustrm_protid, 0);
    chk("t5_state", ustrm_state, 0);
    chk("t5_ack", state_ack, 0);
    chk("t5_level", fifo_level, 0);
    for (int n = 0; n < 10; n++) begin
      tick();
      smp();
      chk("t5_no_stale", ustrm_dvalid, 0);
    end
    tick();

    // Test 6: random valid/online traffic against the scoreboard
    rx0 = rx_cnt;
    acc = 1'b0;
    usr_valid = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!usr_valid || acc) begin
        if ($urandom_range(0, 3) != 0)
          drive($urandom, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        else
          usr_valid = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) tx_online = ~tx_online;
      smp();
      acc = usr_valid && usr_ready;
      tick();
    end
    usr_valid = 1'b0;
    tx_online = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (fifo_level == 0 && exp_q.size() == 0) break;
      tick();
    end
    tick();
    chk("t6_q_empty", exp_q.size(), 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_traffic", rx_cnt - rx0 > 1000, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
